// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, ALU control codes and decode bundle for the
// mips32 decode/execute slice.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_BREAK = 6'h0D;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLTU = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_ZERO = 4'd12;

    localparam logic [1:0] SRC_RR    = 2'b00;
    localparam logic [1:0] SRC_IMM   = 2'b01;
    localparam logic [1:0] SRC_SHAMT = 2'b10;
    localparam logic [1:0] SRC_VAR   = 2'b11;

    typedef struct packed {
        logic [1:0] alu_src;
        logic       alu_op;
        logic [3:0] op_ctrl;
        logic       zext;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       halt;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU: ctrl selects the operation on op1/op2.
// Shift operations exist only when ALU_SHIFT_EN is defined.
module mips_alu
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      ctrl,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] result,
    output logic            zero
);

`ifdef ALU_SHIFT_EN
    logic [4:0] shamt;
    assign shamt = op2[4:0];
`endif

    always_comb begin
        // NOTE: assign a default before the case so no path leaves result unassigned (no latch).
        result = '0;
        case (ctrl)
            ALU_AND:  result = op1 & op2;
            ALU_OR:   result = op1 | op2;
            ALU_ADD:  result = op1 + op2;
            ALU_XOR:  result = op1 ^ op2;
            ALU_NOR:  result = ~(op1 | op2);
            ALU_SUB:  result = op1 - op2;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (op1 < op2)};
            ALU_LUI:  result = op2 << 16;
`ifdef ALU_SHIFT_EN
            ALU_SLL:  result = op1 << shamt;
            ALU_SRL:  result = op1 >> shamt;
            ALU_SRA:  result = $signed(op1) >>> shamt;
`endif
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mips_decode_exec.sv
// Single-cycle MIPS32 decode + execute with one register stage on all outputs.
// Optional ALU_SHIFT_EN enables sll/srl/sra and their variable forms.
module mips_decode_exec
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            reg_dst,
    output logic            reg_write,
    output logic            mem_to_reg,
    output logic            mem_write,
    output logic            branch,
    output logic            jump,
    output logic [27:0]     jump_target,
    output logic            halt,
    output logic            illegal
);

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [4:0]      dest_idx;
    dec_t            dec;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] simm;
    logic [XLEN-1:0] zimm;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign simm     = {{(XLEN-16){instr[15]}}, instr[15:0]};
    assign zimm     = {{(XLEN-16){1'b0}}, instr[15:0]};
    assign dest_idx = dec.reg_dst ? instr[15:11] : instr[20:16];

    // Main decode: anything not matched below stays illegal with all enables low.
    always_comb begin
        dec         = '0;
        dec.op_ctrl = ALU_ZERO;
        dec.illegal = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                dec.illegal   = 1'b0;
                dec.alu_op    = 1'b1;
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                case (funct)
                    F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR,
                    F_XOR, F_NOR, F_SLT, F_SLTU: dec.alu_src = SRC_RR;
`ifdef ALU_SHIFT_EN
                    F_SLL, F_SRL, F_SRA:    dec.alu_src = SRC_SHAMT;
                    F_SLLV, F_SRLV, F_SRAV: dec.alu_src = SRC_VAR;
`endif
                    F_BREAK: begin
                        dec.halt      = 1'b1;
                        dec.reg_write = 1'b0;
                    end
                    default: begin
                        dec.illegal   = 1'b1;
                        dec.alu_op    = 1'b0;
                        dec.reg_dst   = 1'b0;
                        dec.reg_write = 1'b0;
                    end
                endcase
`ifndef ALU_SHIFT_EN
                // The all-zero word is still a legal nop without the shifter.
                if (instr == 32'h0) begin
                    dec.illegal   = 1'b0;
                    dec.alu_op    = 1'b0;
                    dec.reg_write = 1'b0;
                end
`endif
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
            OP_XORI, OP_LUI, OP_LW, OP_SW: begin
                dec.illegal    = 1'b0;
                dec.alu_src    = SRC_IMM;
                dec.reg_write  = (opcode != OP_SW);
                dec.mem_to_reg = (opcode == OP_LW);
                dec.mem_write  = (opcode == OP_SW);
                dec.zext       = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
                case (opcode)
                    OP_SLTI:  dec.op_ctrl = ALU_SLT;
                    OP_SLTIU: dec.op_ctrl = ALU_SLTU;
                    OP_ANDI:  dec.op_ctrl = ALU_AND;
                    OP_ORI:   dec.op_ctrl = ALU_OR;
                    OP_XORI:  dec.op_ctrl = ALU_XOR;
                    OP_LUI:   dec.op_ctrl = ALU_LUI;
                    default:  dec.op_ctrl = ALU_ADD;
                endcase
            end
            OP_BEQ: begin
                dec.illegal = 1'b0;
                dec.alu_src = SRC_RR;
                dec.op_ctrl = ALU_SUB;
                dec.branch  = 1'b1;
            end
            OP_J: begin
                dec.illegal = 1'b0;
                dec.jump    = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // ALU control: R-type funct overrides the opcode-derived operation.
    always_comb begin
        alu_ctrl = dec.op_ctrl;
        if (dec.alu_op) begin
            case (funct)
                F_ADD, F_ADDU: alu_ctrl = ALU_ADD;
                F_SUB, F_SUBU: alu_ctrl = ALU_SUB;
                F_AND:         alu_ctrl = ALU_AND;
                F_OR:          alu_ctrl = ALU_OR;
                F_XOR:         alu_ctrl = ALU_XOR;
                F_NOR:         alu_ctrl = ALU_NOR;
                F_SLT:         alu_ctrl = ALU_SLT;
                F_SLTU:        alu_ctrl = ALU_SLTU;
`ifdef ALU_SHIFT_EN
                F_SLL, F_SLLV: alu_ctrl = ALU_SLL;
                F_SRL, F_SRLV: alu_ctrl = ALU_SRL;
                F_SRA, F_SRAV: alu_ctrl = ALU_SRA;
`endif
                default:       alu_ctrl = ALU_ZERO;
            endcase
        end
    end

    always_comb begin
        op1 = rs_data;
        op2 = rt_data;
        case (dec.alu_src)
            SRC_IMM: begin
                op1 = rs_data;
                op2 = dec.zext ? zimm : simm;
            end
            SRC_SHAMT: begin
                op1 = rt_data;
                op2 = {{(XLEN-5){1'b0}}, instr[10:6]};
            end
            SRC_VAR: begin
                op1 = rt_data;
                op2 = {{(XLEN-5){1'b0}}, rs_data[4:0]};
            end
            default: begin
                op1 = rs_data;
                op2 = rt_data;
            end
        endcase
    end

    mips_alu #(.XLEN(XLEN)) u_alu (
        .ctrl   (alu_ctrl),
        .op1    (op1),
        .op2    (op2),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Side-effect enables are qualified by in_valid; result/zero track the inputs regardless.
    always_ff @(posedge clock) begin
        // NOTE: registered state uses non-blocking assignments; reset is synchronous so it is only seen on a clock edge.
        if (reset) begin
            out_valid   <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            reg_dst     <= 1'b0;
            reg_write   <= 1'b0;
            mem_to_reg  <= 1'b0;
            mem_write   <= 1'b0;
            branch      <= 1'b0;
            jump        <= 1'b0;
            jump_target <= '0;
            halt        <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            out_valid   <= in_valid;
            result      <= alu_result;
            zero        <= alu_zero;
            reg_dst     <= dec.reg_dst;
            reg_write   <= in_valid && dec.reg_write && (dest_idx != 5'd0);
            mem_to_reg  <= dec.mem_to_reg;
            mem_write   <= in_valid && dec.mem_write;
            branch      <= in_valid && dec.branch;
            jump        <= in_valid && dec.jump;
            jump_target <= {instr[25:0], 2'b00};
            halt        <= in_valid && dec.halt;
            illegal     <= in_valid && dec.illegal;
        end
    end

endmodule

// File: tb/tb_mips_decode_exec.sv
// Scoreboard bench for mips_decode_exec; shift vectors depend on ALU_SHIFT_EN.
module tb_mips_decode_exec;

    localparam logic [9:0] FV  = 10'b10_0000_0000;
    localparam logic [9:0] FZ  = 10'b01_0000_0000;
    localparam logic [9:0] FD  = 10'b00_1000_0000;
    localparam logic [9:0] FW  = 10'b00_0100_0000;
    localparam logic [9:0] FMR = 10'b00_0010_0000;
    localparam logic [9:0] FMW = 10'b00_0001_0000;
    localparam logic [9:0] FB  = 10'b00_0000_1000;
    localparam logic [9:0] FJ  = 10'b00_0000_0100;
    localparam logic [9:0] FH  = 10'b00_0000_0010;
    localparam logic [9:0] FI  = 10'b00_0000_0001;

    typedef struct {
        string       tag;
        logic [9:0]  flags;
        logic [9:0]  mask;
        logic [31:0] result;
        bit          chk_res;
        logic [27:0] jt;
        bit          chk_jt;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        reg_dst;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic [27:0] jump_target;
    logic        halt;
    logic        illegal;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mips_decode_exec dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .instr       (instr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .out_valid   (out_valid),
        .result      (result),
        .zero        (zero),
        .reg_dst     (reg_dst),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .mem_write   (mem_write),
        .branch      (branch),
        .jump        (jump),
        .jump_target (jump_target),
        .halt        (halt),
        .illegal     (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue what the DUT must show after the next edge.
    task automatic send(input string tag, input logic rst, input logic vld,
                        input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [9:0] flags, input logic [31:0] res,
                        input bit chk_res, input bit chk_dst);
        exp_t e;
        @(negedge clock);
        reset    = rst;
        in_valid = vld;
        instr    = ins;
        rs_data  = rs;
        rt_data  = rt;
        e.tag     = tag;
        e.flags   = flags;
        e.mask    = 10'h3FF & ~(chk_res ? 10'h0 : FZ) & ~(chk_dst ? 10'h0 : FD);
        e.result  = res;
        e.chk_res = chk_res;
        e.chk_jt  = rst || ((flags & FJ) != 10'h0);
        e.jt      = rst ? 28'h0 : {ins[25:0], 2'b00};
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t       e;
        logic [9:0] got;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {out_valid, zero, reg_dst, reg_write, mem_to_reg,
                       mem_write, branch, jump, halt, illegal};
                check({e.tag, ".flags"}, {22'h0, got & e.mask}, {22'h0, e.flags & e.mask});
                if (e.chk_res) check({e.tag, ".result"}, result, e.result);
                if (e.chk_jt)  check({e.tag, ".jtarget"}, {4'h0, jump_target}, {4'h0, e.jt});
            end
        end
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        instr    = 32'h0;
        rs_data  = 32'h0;
        rt_data  = 32'h0;

        send("reset0", 1, 1, 32'h0022_1820, 32'd5, 32'd7, 10'h0, 32'h0, 1, 1);
        send("reset1", 1, 1, 32'h0022_1820, 32'd5, 32'd7, 10'h0, 32'h0, 1, 1);

        send("add",    0, 1, 32'h0022_1820, 32'd5, 32'd7, FV|FD|FW, 32'd12, 1, 1);
        send("addi",   0, 1, 32'h2022_FFFF, 32'd1, 32'd0, FV|FZ|FW, 32'h0, 1, 1);
        send("ori",    0, 1, 32'h3402_8000, 32'd0, 32'h1234, FV|FW, 32'h0000_8000, 1, 1);
        send("beq_eq", 0, 1, 32'h114B_0001, 32'd9, 32'd9, FV|FZ|FB, 32'h0, 1, 0);
        send("beq_ne", 0, 1, 32'h114B_0001, 32'd9, 32'd8, FV|FB, 32'h1, 1, 0);
        send("sw",     0, 1, 32'hAC22_0008, 32'h100, 32'hDEAD, FV|FMW, 32'h108, 1, 0);
        send("lw",     0, 1, 32'h8C22_0008, 32'h100, 32'hDEAD, FV|FMR|FW, 32'h108, 1, 1);
        send("sub",    0, 1, 32'h0022_1822, 32'd3, 32'd5, FV|FD|FW, 32'hFFFF_FFFE, 1, 1);
        send("slt",    0, 1, 32'h0022_182A, 32'hFFFF_FFFF, 32'd1, FV|FD|FW, 32'h1, 1, 1);
        send("sltu",   0, 1, 32'h0022_182B, 32'hFFFF_FFFF, 32'd1, FV|FZ|FD|FW, 32'h0, 1, 1);
        send("nor",    0, 1, 32'h0022_1827, 32'hF0F0_F0F0, 32'h0F0F_0000, FV|FD|FW, 32'h0000_0F0F, 1, 1);
        send("lui",    0, 1, 32'h3C02_1234, 32'h5555_5555, 32'h0, FV|FW, 32'h1234_0000, 1, 1);
        send("andi",   0, 1, 32'h3022_8001, 32'hFFFF_FFFF, 32'h0, FV|FW, 32'h0000_8001, 1, 1);
        send("wr_r0",  0, 1, 32'h0022_0020, 32'd5, 32'd7, FV|FD, 32'd12, 1, 1);
        send("jump",   0, 1, 32'h0800_0010, 32'h0, 32'h0, FV|FJ, 32'h0, 0, 0);
        send("novalid",0, 0, 32'h0022_1820, 32'd5, 32'd7, 10'h0, 32'd12, 1, 0);
        send("midrst", 1, 1, 32'hAC22_0008, 32'h100, 32'h0, 10'h0, 32'h0, 1, 1);
        send("illegal",0, 1, 32'hFC00_0000, 32'h55, 32'h66, FV|FZ|FI, 32'h0, 1, 1);
        send("break",  0, 1, 32'h0000_000D, 32'h0, 32'h0, FV|FH, 32'h0, 0, 0);
        send("nop",    0, 1, 32'h0000_0000, 32'h0, 32'h0, FV, 32'h0, 0, 0);
`ifdef ALU_SHIFT_EN
        send("sll",    0, 1, 32'h0002_1900, 32'h0, 32'd1, FV|FD|FW, 32'd16, 1, 1);
        send("sra",    0, 1, 32'h0002_1903, 32'h0, 32'h8000_0000, FV|FD|FW, 32'hF800_0000, 1, 1);
        send("srlv",   0, 1, 32'h0022_1806, 32'd1, 32'h80, FV|FD|FW, 32'h40, 1, 1);
`else
        send("sll_off",0, 1, 32'h0002_1900, 32'h0, 32'd1, FV|FZ|FI, 32'h0, 1, 1);
        send("srlv_off",0,1, 32'h0022_1806, 32'd1, 32'h80, FV|FZ|FI, 32'h0, 1, 1);
`endif

        @(negedge clock);
        in_valid = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
        #2;
        check("drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
